// File: rtl/lsu_addr_calc_pkg.sv
// Shared LSU constants: lane geometry, format-class codes and descriptor field
// positions used by the address-generation path.
package lsu_addr_calc_pkg;

   localparam int NUM_LANES = 64;
   localparam int ADDR_W    = 32;
   localparam int TOTAL_W   = NUM_LANES * ADDR_W;

   localparam logic [7:0] FMT_SMRD  = 8'h01;
   localparam logic [7:0] FMT_MTBUF = 8'h02;

   localparam int RSRC_BASE_LO = 0;
   localparam int RSRC_BASE_HI = 31;

   typedef logic [ADDR_W-1:0] addr_t;

   function automatic addr_t zext_imm(input logic [15:0] imm);
      return {16'h0000, imm};
   endfunction

endpackage

// File: rtl/lsu_lane_addr.sv
// Single-lane address adder: base + scalar offset + immediate + optional
// per-lane vector address.
module lsu_lane_addr
   import lsu_addr_calc_pkg::*;
(
   input  addr_t base,
   input  addr_t soffset,
   input  addr_t offset,
   input  addr_t vaddr,
   input  logic  vaddr_en,
   output addr_t sum
);

   // AND-masking keeps X/Z on an unused vaddr from reaching the sum.
   assign sum = base + soffset + offset + (vaddr & {ADDR_W{vaddr_en}});

endmodule

// File: rtl/lsu_addr_calc.sv
// Per-lane memory address generator for the wavefront LSU; decodes the format
// class and registers one 32-bit byte address per lane.
module lsu_addr_calc
   import lsu_addr_calc_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   output logic [TOTAL_W-1:0] out_addr,
   input  logic [127:0]       resource_buffer,
   input  logic [TOTAL_W-1:0] vreg_value,
   input  logic [31:0]        sreg_value,
   input  logic [15:0]        imm_value,
   input  logic [15:0]        opcode
);

   logic [7:0]         fmt_s;
   addr_t              base_s;
   addr_t              imm_s;
   logic               vaddr_en_s;
   logic [TOTAL_W-1:0] lane_sum_s;
   logic [TOTAL_W-1:0] next_addr_s;
   logic [TOTAL_W-1:0] out_addr_r;
   logic               unused_s;

   assign fmt_s      = opcode[15:8];
   assign base_s     = resource_buffer[RSRC_BASE_HI:RSRC_BASE_LO];
   assign imm_s      = zext_imm(imm_value);
   assign vaddr_en_s = (fmt_s == FMT_MTBUF);

   // Upper descriptor words and the operation byte are reserved.
   assign unused_s = ^{resource_buffer[127:RSRC_BASE_HI+1], opcode[7:0]};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      lsu_lane_addr u_lane (
         .base     (base_s),
         .soffset  (sreg_value),
         .offset   (imm_s),
         .vaddr    (vaddr_en_s ? vreg_value[ADDR_W*i +: ADDR_W] : {ADDR_W{1'b0}}),
         .vaddr_en (vaddr_en_s),
         .sum      (lane_sum_s[ADDR_W*i +: ADDR_W])
      );
   end

   // Select which lanes carry a live address for this format class.
   always_comb begin
      next_addr_s = {TOTAL_W{1'b0}};
      case (fmt_s)
         FMT_SMRD:  next_addr_s = {{(TOTAL_W-ADDR_W){1'b0}}, lane_sum_s[ADDR_W-1:0]};
         FMT_MTBUF: next_addr_s = lane_sum_s;
         default:   next_addr_s = {TOTAL_W{1'b0}};
      endcase
   end

   // Output register; reset overrides any inputs presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_addr_r <= {TOTAL_W{1'b0}};
      end else begin
         out_addr_r <= next_addr_s;
      end
   end

   assign out_addr = out_addr_r;

endmodule

// File: tb/tb_lsu_addr_calc.sv
// Directed and randomized checks of lsu_addr_calc against an arithmetic model
// of the per-lane addressing rules.
module tb_lsu_addr_calc;

   localparam int LANES = 64;
   localparam int TW    = LANES * 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [TW-1:0] out_addr;
   logic [127:0]  resource_buffer;
   logic [TW-1:0] vreg_value;
   logic [31:0]   sreg_value;
   logic [15:0]   imm_value;
   logic [15:0]   opcode;

   int checks = 0;
   int errors = 0;

   lsu_addr_calc dut (
      .clk             (clk),
      .rst             (rst),
      .out_addr        (out_addr),
      .resource_buffer (resource_buffer),
      .vreg_value      (vreg_value),
      .sreg_value      (sreg_value),
      .imm_value       (imm_value),
      .opcode          (opcode)
   );

   always #5 clk = ~clk;

   function automatic logic [TW-1:0] model(input logic [127:0] rb, input logic [TW-1:0] vr,
                                           input logic [31:0] sr, input logic [15:0] im,
                                           input logic [15:0] op, input logic r);
      logic [TW-1:0] res;
      int unsigned   scalar;
      int unsigned   lane_val;
      res = '0;
      scalar = rb[31:0] + sr + {16'h0000, im};
      if (!r) begin
         if (op[15:8] == 8'h01) begin
            res[31:0] = scalar;
         end else if (op[15:8] == 8'h02) begin
            for (int i = 0; i < LANES; i++) begin
               lane_val = scalar + vr[32*i +: 32];
               res[32*i +: 32] = lane_val;
            end
         end
      end
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [TW-1:0] exp);
      int bad;
      bad = -1;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (out_addr[32*i +: 32] !== exp[32*i +: 32]) bad = i;
      end
      checks++;
      assert (out_addr === exp) else begin
         errors++;
         $error("FAIL %s first_bad_lane=%0d observed=%h expected=%h (lane0 obs=%h exp=%h)",
                tag, bad, (bad >= 0) ? out_addr[32*bad +: 32] : 32'h0,
                (bad >= 0) ? exp[32*bad +: 32] : 32'h0, out_addr[31:0], exp[31:0]);
      end
   endtask

   task automatic check_lane(input string tag, input int lane, input logic [31:0] exp);
      checks++;
      assert (out_addr[32*lane +: 32] === exp) else begin
         errors++;
         $error("FAIL %s lane=%0d observed=%h expected=%h", tag, lane, out_addr[32*lane +: 32], exp);
      end
   endtask

   initial begin
      logic [TW-1:0] exp;
      logic [15:0]   op_rand;

      // Reset held two cycles with arbitrary inputs.
      rst = 1'b1;
      resource_buffer = {$urandom, $urandom, $urandom, $urandom};
      sreg_value = $urandom;
      imm_value  = 16'($urandom);
      opcode     = 16'h0218;
      for (int i = 0; i < LANES; i++) vreg_value[32*i +: 32] = $urandom;
      tick();
      check_all("reset_edge1", '0);
      tick();
      check_all("reset_edge2", '0);

      // Scalar load with undriven vector operands.
      rst = 1'b0;
      resource_buffer = 128'h2;
      sreg_value = 32'h3;
      imm_value  = 16'h4;
      opcode     = 16'h0128;
      vreg_value = {TW{1'bx}};
      tick();
      check_lane("smrd_lane0", 0, 32'h9);
      check_all("smrd_all", {{(TW-32){1'b0}}, 32'h9});
      checks++;
      assert ($isunknown(out_addr) === 1'b0) else begin
         errors++;
         $error("FAIL smrd_no_x observed=unknown expected=known");
      end

      // Vector load.
      vreg_value = {{(TW-1){1'b0}}, 1'b1};
      opcode     = 16'h0218;
      tick();
      check_lane("mtbuf_lane0", 0, 32'hA);
      check_lane("mtbuf_lane1", 1, 32'h9);
      check_lane("mtbuf_lane63", 63, 32'h9);

      // Per-lane independence.
      resource_buffer = 128'h1000;
      sreg_value = 32'h0;
      imm_value  = 16'h0;
      for (int i = 0; i < LANES; i++) vreg_value[32*i +: 32] = 32'(4 * i);
      tick();
      check_lane("indep_lane63", 63, 32'h10FC);
      check_lane("indep_lane17", 17, 32'h1044);
      check_all("indep_all", model(resource_buffer, vreg_value, sreg_value, imm_value, opcode, 1'b0));

      // Wrap-around then unknown class.
      resource_buffer = 128'hFFFF_FFFF;
      sreg_value = 32'h1;
      imm_value  = 16'h0;
      vreg_value = '0;
      tick();
      check_all("wrap_all_zero", '0);
      opcode = 16'h0700;
      resource_buffer = 128'h1234;
      tick();
      check_all("unknown_class", '0);

      // Reset pulse in the middle of back-to-back vector ops.
      opcode = 16'h02FF;
      for (int i = 0; i < LANES; i++) vreg_value[32*i +: 32] = $urandom;
      sreg_value = $urandom;
      tick();
      check_all("mid_before", model(resource_buffer, vreg_value, sreg_value, imm_value, opcode, 1'b0));
      rst = 1'b1;
      sreg_value = $urandom;
      tick();
      check_all("mid_reset", '0);
      rst = 1'b0;
      imm_value = 16'hBEEF;
      tick();
      check_all("mid_after", model(resource_buffer, vreg_value, sreg_value, imm_value, opcode, 1'b0));

      // Randomized traffic over all format classes with occasional reset.
      for (int n = 0; n < 60; n++) begin
         resource_buffer = {$urandom, $urandom, $urandom, $urandom};
         for (int i = 0; i < LANES; i++) vreg_value[32*i +: 32] = $urandom;
         sreg_value = $urandom;
         imm_value  = 16'($urandom);
         op_rand    = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       opcode = {8'h01, op_rand[7:0]};
            1:       opcode = {8'h02, op_rand[7:0]};
            default: opcode = op_rand;
         endcase
         rst = ($urandom_range(0, 9) == 0);
         exp = model(resource_buffer, vreg_value, sreg_value, imm_value, opcode, rst);
         tick();
         check_all("random", exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
